data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder end of the memory-access-stage data interface. It accepts one load/store request at a time from the MEM stage and holds it in an internal word-organised data RAM. Each request completes after a programmable latency and is acknowledged with a single-cycle response pulse. While a request is outstanding it asserts `stall` so the pipeline freezes.

Parameters:
- ADDR_W, 10: word-index width; RAM depth = 2**ADDR_W 32-bit words.
- LATENCY, 2: cycles from accept to response pulse; legal range 1..15.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data, right-aligned, zero-extended
- resp_err  out  1  misaligned access flag, valid with resp_valid
- stall  out  1  pipeline stall request

Behaviour:
- Reset, sampled on a clk edge with rst=0:
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; wait counter = 0.
  - RAM contents are not reset.
  - Reset in any state aborts the outstanding request. A store that has not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
  - stall = (state != IDLE), combinational.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. The block latches req_we, req_size, req_addr and req_wdata at that edge.
- Transitions out of IDLE on accept:
  - LATENCY == 1: go to RESP.
  - Otherwise: go to WAIT with counter = LATENCY-2.
- WAIT: decrement the counter each cycle; at counter == 0 go to RESP.
- Commit: the store (RAM write) and the load sample (into the resp_rdata register) both occur at the edge entering RESP.
- Timing: if a request is accepted at edge T, resp_valid is high for exactly the cycle after edge T+LATENCY-1. In other words, the first cycle of RESP.
- RESP: resp_valid = 1 for exactly one cycle, then unconditionally go to IDLE. resp_valid deasserts in IDLE.
- Throughput: at most one request per LATENCY+1 cycles.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so the RAM aliases (wraps) modulo its depth.
- Byte lanes are little-endian.
  - Byte: lane addr[1:0]; store writes only that byte.
  - Half: lane addr[1] (bytes 0-1 or 2-3); store writes only those two bytes.
  - Word: writes all 4 bytes.
- Loads: resp_rdata holds the selected lane shifted to bit 0, upper bits zero. Sign extension is performed downstream in the MEM stage.
- Stores: resp_rdata = 0 during the response pulse.
- A req_valid arriving while state != IDLE is not accepted. The requester holds it until req_ready.
- Between responses, resp_rdata holds its last value. Consumers must qualify it with resp_valid.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN
- Defined:
  - A half access with addr[0]=1, or a word/reserved access with addr[1:0]!=0, is misaligned.
  - A misaligned access still takes full LATENCY and produces a resp_valid pulse.
  - It performs no RAM write and returns resp_rdata = 0 with resp_err = 1.
  - Aligned accesses return resp_err = 0.
- Undefined:
  - resp_err is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - No access is suppressed.

Test Plan:
1. LATENCY=2: store word 0xDEADBEEF to 0x40, then load word 0x40. Required: each resp_valid is exactly 2 cycles after accept; load returns 0xDEADBEEF; stall is high during both operations; req_ready is low.
2. Store byte 0xAA to 0x41 over 0x11223344 at 0x40, then load word 0x40. Required: 0x1122AA44; load byte 0x41 returns 0x000000AA.
3. Store half 0xBEEF to 0x42 (word previously 0x11223344), then load half 0x42. Required: 0x0000BEEF; word at 0x40 reads 0xBEEF3344.
4. Hold req_valid for a second request during WAIT. Required: it is accepted only in the cycle after the first request's RESP; no request is lost or duplicated.
5. Assert rst=0 during WAIT of a store to 0x80 (old value 0x0). Required: outputs reach reset values at the next edge; a later load of 0x80 returns 0x00000000.
6. With DMEM_ALIGN_CHECK_EN: store word to 0x43. Required: resp_err=1, resp_rdata=0, target word unchanged. Without the macro the same store writes the word at 0x40 and resp_err=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data
// memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, completes it
// after LATENCY cycles into a byte-lane word RAM and pulses resp_valid.
// Optional macro DMEM_ALIGN_CHECK_EN flags and suppresses misaligned
// half/word accesses; without it resp_err is tied low.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic        commit;
    logic        op_we;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [ADDR_W-1:0] idx;
    logic        misalign;
    logic [3:0]  be;
    logic [3:0]  ram_we;
    logic [31:0] wdata_sh;
    logic [31:0] rd_word;
    logic [31:0] byte_sh;
    logic [31:0] load_val;
    logic        unused_addr_bits;

    assign accept         = bus.req_valid && (state_q == IDLE);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.stall      = (state_q != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Operation in flight: live inputs in IDLE (LATENCY==1 commits on the accept edge), latched copy otherwise
    always_comb begin
        op_we    = we_q;
        op_size  = size_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == IDLE) begin
            op_we    = bus.req_we;
            op_size  = bus.req_size;
            op_addr  = bus.req_addr;
            op_wdata = bus.req_wdata;
        end
    end

    assign idx              = op_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^op_addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((op_size == 2'b01) && op_addr[0]) ||
                      (op_size[1] && (op_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the access size
    always_comb begin
        be       = 4'b1111;
        wdata_sh = op_wdata;
        case (op_size)
            2'b00: begin
                be       = 4'b0001 << op_addr[1:0];
                wdata_sh = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                be       = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{op_wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wdata_sh = op_wdata;
            end
        endcase
    end

    // Write only on a committing, non-suppressed store; reset wins over commit
    assign ram_we = (commit && rst && op_we && !misalign) ? be : 4'b0000;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_lane
            logic [7:0] ram [DEPTH];

            // One byte lane of the word RAM
            always_ff @(posedge clk) begin
                if (ram_we[gi]) begin
                    ram[idx] <= wdata_sh[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = ram[idx];
        end
    endgenerate

    assign byte_sh = rd_word >> {op_addr[1:0], 3'b000};

    // Right-align and zero-extend the selected lane for loads
    always_comb begin
        load_val = rd_word;
        case (op_size)
            2'b00:   load_val = {24'b0, byte_sh[7:0]};
            2'b01:   load_val = {16'b0, (op_addr[1] ? rd_word[31:16] : rd_word[15:0])};
            default: load_val = rd_word;
        endcase
    end

    // Next-state, wait counter, request capture and response registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        commit       = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            resp_valid_d = 1'b1;
            resp_err_d   = misalign;
            resp_rdata_d = (op_we || misalign) ? 32'd0 : load_val;
        end
    end

    // Control and response state, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Captured request fields; only meaningful while a request is in flight
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (ADDR_W=10, LATENCY=2).
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request from IDLE and follow it to its response pulse.
    // lat counts edges from accept to the edge raising resp_valid (inclusive).
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output logic busy_ok);
        busy_ok       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            if (!bus.stall || bus.req_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.stall || bus.req_ready) busy_ok = 1'b0;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        $display("req we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, size, addr, wdata, rdata, err, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_resp_rdata got=%h want=00000000", bus.resp_rdata); end
        total++; if (bus.resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", bus.resp_err); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h40, 32'hDEADBEEF, rd, er, lat, bz);
        total++; if (lat != LAT) begin bad++; $display("FAIL word_store_latency got=%0d want=%0d", lat, LAT); end
        total++; if (bz !== 1'b1) begin bad++; $display("FAIL word_store_stall got=%b want=1", bz); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL word_store_rdata got=%h want=00000000", rd); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL word_pulse_width got=%b want=0", bus.resp_valid); end
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (lat != LAT) begin bad++; $display("FAIL word_load_latency got=%0d want=%0d", lat, LAT); end
        total++; if (bz !== 1'b1) begin bad++; $display("FAIL word_load_stall got=%b want=1", bz); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load_rdata got=%h want=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL word_load_err got=%b want=0", er); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h40, 32'h11223344, rd, er, lat, bz);
        do_req(1'b1, 2'b00, 32'h41, 32'h000000AA, rd, er, lat, bz);
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL byte_word_readback got=%h want=1122aa44", rd); end
        do_req(1'b0, 2'b00, 32'h41, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL byte_load_41 got=%h want=000000aa", rd); end
        do_req(1'b0, 2'b00, 32'h43, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h00000011) begin bad++; $display("FAIL byte_load_43 got=%h want=00000011", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h40, 32'h11223344, rd, er, lat, bz);
        do_req(1'b1, 2'b01, 32'h42, 32'h0000BEEF, rd, er, lat, bz);
        do_req(1'b0, 2'b01, 32'h42, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL half_load_42 got=%h want=0000beef", rd); end
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'hBEEF3344) begin bad++; $display("FAIL half_word_readback got=%h want=beef3344", rd); end
        do_req(1'b0, 2'b01, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h00003344) begin bad++; $display("FAIL half_load_40 got=%h want=00003344", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h0000_1040, 32'hCAFEF00D, rd, er, lat, bz);
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_wrap got=%h want=cafef00d", rd); end
        do_req(1'b1, 2'b10, 32'h0000_0FFC, 32'hA5A5_0F0F, rd, er, lat, bz);
        do_req(1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'hA5A50F0F) begin bad++; $display("FAIL alias_top_word got=%h want=a5a50f0f", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0; int accepts = 0; int acc_at = -1; int resp2_at = -1;
        logic drop = 1'b0; logic [31:0] r2 = 32'd0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h12345678;
        @(posedge clk); #1;
        bus.req_we = 1'b0; bus.req_wdata = 32'h0;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_wait got=%b want=0", bus.req_ready); end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (drop) begin bus.req_valid = 1'b0; drop = 1'b0; end
            if (bus.resp_valid) begin
                pulses++;
                if (pulses == 2) begin r2 = bus.resp_rdata; resp2_at = i; end
            end
            if (bus.req_valid && bus.req_ready) begin accepts++; acc_at = i; drop = 1'b1; end
        end
        bus.req_valid = 1'b0;
        $display("b2b pulses=%0d accepts=%0d acc_at=%0d resp2_at=%0d r2=%h", pulses, accepts, acc_at, resp2_at, r2);
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
        total++; if (accepts != 1) begin bad++; $display("FAIL b2b_accepts got=%0d want=1", accepts); end
        total++; if (acc_at != 2) begin bad++; $display("FAIL b2b_accept_cycle got=%0d want=2", acc_at); end
        total++; if (resp2_at != 4) begin bad++; $display("FAIL b2b_resp2_cycle got=%0d want=4", resp2_at); end
        total++; if (r2 !== 32'h12345678) begin bad++; $display("FAIL b2b_load_data got=%h want=12345678", r2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h80, 32'h0, rd, er, lat, bz);
        do_req(1'b0, 2'b10, 32'h100, 32'h0, rd, er, lat, bz);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h80; bus.req_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("mid-reset stall=%b ready=%b rv=%b rdata=%h err=%b",
                 bus.stall, bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", bus.stall); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", bus.req_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL midrst_resp_valid got=%b want=0", bus.resp_valid); end
        total++; if (bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL midrst_rdata got=%h want=00000000", bus.resp_rdata); end
        rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 2'b10, 32'h80, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h00000000) begin bad++; $display("FAIL midrst_store_discarded got=%h want=00000000", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic er; int lat; logic bz;
        do_req(1'b1, 2'b10, 32'h40, 32'h99887766, rd, er, lat, bz);
        do_req(1'b1, 2'b10, 32'h43, 32'h01020304, rd, er, lat, bz);
        total++; if (lat != LAT) begin bad++; $display("FAIL align_latency got=%0d want=%0d", lat, LAT); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL align_store_rdata got=%h want=00000000", rd); end
`ifdef DMEM_ALIGN_CHECK_EN
        total++; if (er !== 1'b1) begin bad++; $display("FAIL align_err got=%b want=1", er); end
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h99887766) begin bad++; $display("FAIL align_word_unchanged got=%h want=99887766", rd); end
        do_req(1'b0, 2'b01, 32'h41, 32'h0, rd, er, lat, bz);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL align_half_err got=%b want=1", er); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL align_half_rdata got=%h want=00000000", rd); end
`else
        total++; if (er !== 1'b0) begin bad++; $display("FAIL align_err got=%b want=0", er); end
        do_req(1'b0, 2'b10, 32'h40, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL align_word_written got=%h want=01020304", rd); end
        do_req(1'b0, 2'b01, 32'h41, 32'h0, rd, er, lat, bz);
        total++; if (rd !== 32'h00000304) begin bad++; $display("FAIL align_half_ignore_a0 got=%h want=00000304", rd); end
`endif
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
